// File: rtl/gs_recip_scaler_if.sv
// Handshake/bus bundle for gs_recip_scaler.
//   slave  : the scaler's view (reciprocal + numerator in, result/status out)
//   master : the driving/consuming environment's view
interface gs_recip_scaler_if #(
    parameter int unsigned NUM_W = 32,
    parameter int unsigned CNT_W = 8
);
    logic             i_recip_valid;
    logic [31:0]      i_recip;
    logic             i_clear;
    logic             i_num_valid;
    logic [NUM_W-1:0] i_num;
    logic             o_num_ready;
    logic             o_valid;
    logic [NUM_W-1:0] o_result;
    logic             i_out_ready;
    logic             o_armed;
    logic [CNT_W-1:0] o_count;

    modport slave (
        input  i_recip_valid, i_recip, i_clear, i_num_valid, i_num, i_out_ready,
        output o_num_ready, o_valid, o_result, o_armed, o_count
    );

    modport master (
        output i_recip_valid, i_recip, i_clear, i_num_valid, i_num, i_out_ready,
        input  o_num_ready, o_valid, o_result, o_armed, o_count
    );
endinterface

// File: rtl/gs_recip_scaler.sv
// Gauss-Seidel reciprocal scaler: captures the S1.30 reciprocal of a_ii once,
// then multiplies each residual numerator by it (2-stage pipeline, round half
// up, saturate) to produce x_i.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   bus.i_recip_valid/i_recip : reciprocal offer (first valid cycle captured)
//   bus.i_clear           : flush pipeline, drop reciprocal, re-arm
//   bus.i_num_valid/i_num/o_num_ready : numerator handshake
//   bus.o_valid/o_result/i_out_ready  : result handshake
//   bus.o_armed           : reciprocal held
//   bus.o_count           : results delivered since last capture
module gs_recip_scaler #(
    parameter int unsigned NUM_W = 32,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    gs_recip_scaler_if.slave      bus
);
    localparam int unsigned RECIP_W    = 32;
    localparam int unsigned RECIP_FRAC = 30;
    localparam int unsigned PROD_W     = NUM_W + RECIP_W;
    // Product carries FRAC+30 fraction bits; the result keeps FRAC of them.
    localparam int unsigned PROD_FRAC  = FRAC + RECIP_FRAC;
    localparam int unsigned SHIFT      = PROD_FRAC - FRAC;

    localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(1) << (SHIFT - 1);
    localparam logic signed [PROD_W-1:0] RES_MAX =
        {{(PROD_W-NUM_W+1){1'b0}}, {(NUM_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] RES_MIN =
        {{(PROD_W-NUM_W+1){1'b1}}, {(NUM_W-1){1'b0}}};

    typedef enum logic [0:0] {
        WAIT_RECIP = 1'b0,
        RUN        = 1'b1
    } state_t;

    state_t                    state_q,    state_d;
    logic signed [RECIP_W-1:0] recip_q,    recip_d;
    logic                      s1_valid_q, s1_valid_d;
    logic signed [PROD_W-1:0]  s1_prod_q,  s1_prod_d;
    logic                      s2_valid_q, s2_valid_d;
    logic [NUM_W-1:0]          result_q,   result_d;
    logic [CNT_W-1:0]          count_q,    count_d;

    logic                      adv;
    logic                      num_ready_c;
    logic                      accept;
    logic signed [NUM_W-1:0]   num_s;
    logic signed [PROD_W-1:0]  rounded;

    assign num_s = bus.i_num;

    // Next-state, pipeline and counter logic.
    always_comb begin
        state_d    = state_q;
        recip_d    = recip_q;
        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        count_d    = count_q;

        // Both stages move together whenever the output slot can drain.
        adv         = !s2_valid_q || bus.i_out_ready;
        num_ready_c = (state_q == RUN) && adv && !bus.i_clear && !i_reset;
        accept      = bus.i_num_valid && num_ready_c;

        // Arithmetic shift after adding one half: ties round toward +inf.
        rounded = (s1_prod_q + ROUND_HALF) >>> SHIFT;

        if (adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_prod_d = PROD_W'(num_s) * PROD_W'(recip_q);
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (rounded > RES_MAX) begin
                    result_d = {1'b0, {(NUM_W-1){1'b1}}};
                end else if (rounded < RES_MIN) begin
                    result_d = {1'b1, {(NUM_W-1){1'b0}}};
                end else begin
                    result_d = rounded[NUM_W-1:0];
                end
            end
        end

        if (s2_valid_q && bus.i_out_ready) begin
            count_d = count_q + CNT_W'(1);
        end

        if (state_q == WAIT_RECIP && bus.i_recip_valid) begin
            recip_d = bus.i_recip;
            state_d = RUN;
            count_d = '0;
        end

        // Clear overrides capture, accept and handshake in the same cycle.
        if (bus.i_clear) begin
            state_d    = WAIT_RECIP;
            recip_d    = '0;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            result_d   = '0;
            count_d    = '0;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= WAIT_RECIP;
            recip_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            recip_q    <= recip_d;
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            count_q    <= count_d;
        end
    end

    assign bus.o_num_ready = num_ready_c;
    assign bus.o_valid     = s2_valid_q;
    assign bus.o_result    = result_q;
    assign bus.o_armed     = (state_q == RUN);
    assign bus.o_count     = count_q;
endmodule
